// File: rtl/mem_wr_packer_if.sv
// Handshake/bus bundle between the UART/ALU side and the memory write packer.
// The packer takes the slave view; the producer/memory model takes the master view.
interface mem_wr_packer_if #(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 16,
  parameter int RES_W  = 16,
  parameter int ADDR_W = 4
);
  logic [3:0]        controll;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic [RES_W-1:0]  alu_result;
  logic              alu_valid;
  logic              wr_ready;
  logic [WORD_W-1:0] din;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              rx_ready;
  logic              overflow;
  logic              wrapped;

  modport master (
    output controll, rx_data, rx_valid, alu_result, alu_valid, wr_ready,
    input  din, wr_addr, wr_en, rx_ready, overflow, wrapped
  );

  modport slave (
    input  controll, rx_data, rx_valid, alu_result, alu_valid, wr_ready,
    output din, wr_addr, wr_en, rx_ready, overflow, wrapped
  );
endinterface

// File: rtl/mem_wr_packer.sv
// Packs rx bytes little-endian into memory words (or formats ALU results) and
// issues one held write per word with an auto-incrementing, wrapping address.
module mem_wr_packer #(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 16,
  parameter int RES_W  = 16,
  parameter int ADDR_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  mem_wr_packer_if.slave bus
);
  localparam int NB    = WORD_W / BYTE_W;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(NB - 1);

  localparam logic [3:0] OP_VOID     = 4'b0000;
  localparam logic [3:0] OP_LOAD     = 4'b0001;
  localparam logic [3:0] OP_SHOWMOVE = 4'b0100;
  localparam logic [3:0] OP_SHOWADD  = 4'b0110;
  localparam logic [3:0] OP_SHOWSUB  = 4'b1000;
  localparam logic [3:0] OP_SHOWMUL  = 4'b1010;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [CNT_W-1:0]  cnt_p0;
  logic              ovf_p0;
  logic              wrap_p0;

  // Zero-extends a narrow result or keeps the low WORD_W bits of a wide one.
  function automatic logic [WORD_W-1:0] fit_result(input logic [RES_W-1:0] r);
    logic [RES_W+WORD_W-1:0] ext;
    ext = {{WORD_W{1'b0}}, r};
    return ext[WORD_W-1:0];
  endfunction

  function automatic logic is_show(input logic [3:0] op);
    return (op == OP_SHOWMOVE) || (op == OP_SHOWADD) ||
           (op == OP_SHOWSUB)  || (op == OP_SHOWMUL);
  endfunction

  logic is_load, take_first, take_alu, take_byte, flush, last_byte;

  assign is_load    = (bus.controll == OP_LOAD);
  assign take_first = (state_q == IDLE) && is_load && bus.rx_valid;
  assign take_alu   = (state_q == IDLE) && is_show(bus.controll) && bus.alu_valid;
  assign take_byte  = (state_q == COLLECT) && is_load && bus.rx_valid;
  assign flush      = (state_q == COLLECT) && !is_load;
  assign last_byte  = (cnt_p0 == LAST_LANE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_first)    state_d = (NB == 1) ? WRITE : COLLECT;
        else if (take_alu) state_d = WRITE;
      end
      COLLECT: begin
        if (flush || (take_byte && last_byte)) state_d = WRITE;
      end
      WRITE: begin
        if (bus.wr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.wr_en    = (state_q == WRITE);
    bus.rx_ready = (state_q != WRITE);
  end

  // Word/address stage: lanes above the first byte are cleared so a flushed
  // partial word carries zeros in its unfilled lanes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_p0 <= '0;
      addr_p0 <= '0;
      cnt_p0  <= '0;
      ovf_p0  <= 1'b0;
      wrap_p0 <= 1'b0;
    end else begin
      wrap_p0 <= 1'b0;
      if (take_first) begin
        word_p0 <= WORD_W'(bus.rx_data);
        cnt_p0  <= CNT_W'(1);
      end else if (take_alu) begin
        word_p0 <= fit_result(bus.alu_result);
      end else if (take_byte) begin
        word_p0[int'(cnt_p0)*BYTE_W +: BYTE_W] <= bus.rx_data;
        cnt_p0 <= cnt_p0 + 1'b1;
      end
      if ((state_q == IDLE) && (bus.controll == OP_VOID)) begin
        addr_p0 <= '0;
        ovf_p0  <= 1'b0;
      end
      if (state_q == WRITE) begin
        if (bus.rx_valid) ovf_p0 <= 1'b1;
        if (bus.wr_ready) begin
          addr_p0 <= addr_p0 + 1'b1;
          cnt_p0  <= '0;
          wrap_p0 <= (addr_p0 == {ADDR_W{1'b1}});
        end
      end
    end
  end

  assign bus.din      = word_p0;
  assign bus.wr_addr  = addr_p0;
  assign bus.overflow = ovf_p0;
  assign bus.wrapped  = wrap_p0;
endmodule

// File: tb/tb_mem_wr_packer.sv
// Scoreboard bench for mem_wr_packer: stimulus pushes expected writes, a
// negedge monitor pops and compares every write the DUT presents.
module tb_mem_wr_packer;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int RES_W  = 24;
  localparam int ADDR_W = 2;
  localparam int NB     = WORD_W / BYTE_W;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [3:0] OP_VOID    = 4'b0000;
  localparam logic [3:0] OP_LOAD    = 4'b0001;
  localparam logic [3:0] OP_SHOWADD = 4'b0110;
  localparam logic [3:0] OP_SHOWSUB = 4'b1000;
  localparam logic [3:0] OP_SHOWMUL = 4'b1010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wr_packer_if #(.BYTE_W(BYTE_W), .WORD_W(WORD_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

  mem_wr_packer #(.BYTE_W(BYTE_W), .WORD_W(WORD_W), .RES_W(RES_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int                addr;
    logic [WORD_W-1:0] data;
  } wr_t;

  wr_t              exp_q[$];
  logic [BYTE_W-1:0] byte_q[$];
  int  tests = 0;
  int  fails = 0;
  int  exp_addr = 0;
  bit  exp_ovf = 1'b0;
  int  exp_wraps = 0;
  int  seen_wraps = 0;
  int  ready_mode = 0;   // 0 random, 1 always ready, 2 never ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a word is the collected bytes placed lane by lane, first byte lowest.
  task automatic push_word(input logic [WORD_W-1:0] data);
    wr_t w;
    w.addr = exp_addr;
    w.data = data;
    exp_q.push_back(w);
    if (exp_addr == DEPTH - 1) exp_wraps++;
    exp_addr = (exp_addr + 1) % DEPTH;
  endtask

  task automatic push_bytes();
    logic [WORD_W-1:0] d;
    d = '0;
    for (int i = 0; i < byte_q.size(); i++)
      d = d | (WORD_W'(byte_q[i]) << (BYTE_W * i));
    push_word(d);
    byte_q.delete();
  endtask

  task automatic wait_rx_ready(input string name);
    int n;
    n = 0;
    while (!bus.rx_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.rx_ready) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: rx_ready stayed 0 for %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic send_byte(input logic [BYTE_W-1:0] b);
    bus.controll = OP_LOAD;
    wait_rx_ready("byte");
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    byte_q.push_back(b);
    if (byte_q.size() == NB) push_bytes();
  endtask

  task automatic flush(input logic [3:0] op, input bit with_byte);
    bus.controll = op;
    bus.rx_valid = with_byte;
    bus.rx_data  = BYTE_W'($urandom);
    tick();
    bus.rx_valid = 1'b0;
    push_bytes();
  endtask

  task automatic alu_write(input logic [3:0] op, input logic [RES_W-1:0] val);
    logic [RES_W-1:0] v;
    v = val;
    bus.controll = op;
    wait_rx_ready("alu");
    bus.alu_result = val;
    bus.alu_valid  = 1'b1;
    tick();
    bus.alu_valid  = 1'b0;
    push_word(v[WORD_W-1:0]);
  endtask

  function automatic logic [3:0] quiet_op();
    logic [3:0] op;
    do op = 4'($urandom_range(2, 15));
    while (op == 4'd4 || op == 4'd6 || op == 4'd8 || op == 4'd10);
    return op;
  endfunction

  task automatic idle_op();
    bus.controll = quiet_op();
    wait_rx_ready("idle_op");
    bus.rx_valid   = 1'($urandom);
    bus.alu_valid  = 1'($urandom);
    bus.rx_data    = BYTE_W'($urandom);
    bus.alu_result = RES_W'($urandom);
    tick();
    bus.rx_valid  = 1'b0;
    bus.alu_valid = 1'b0;
  endtask

  task automatic void_op();
    check("overflow_before_void", bus.overflow, exp_ovf);
    bus.controll = OP_VOID;
    if (byte_q.size() != 0) push_bytes();
    tick();
    wait_rx_ready("void");
    tick();
    exp_addr = 0;
    exp_ovf  = 1'b0;
    check("void_wr_addr", bus.wr_addr, 0);
    check("void_overflow", bus.overflow, 0);
  endtask

  // Stall the write, drop a byte into it, then release.
  task automatic drop_test(input int stall);
    bus.controll = OP_LOAD;
    wait_rx_ready("drop");
    ready_mode = 2;
    for (int i = 0; i < NB; i++) send_byte(BYTE_W'($urandom));
    bus.rx_data  = BYTE_W'($urandom);
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    for (int i = 1; i < stall; i++) tick();
    exp_ovf = 1'b1;
    check("drop_overflow", bus.overflow, 1);
    check("drop_wr_en_held", bus.wr_en, 1);
    check("drop_rx_ready", bus.rx_ready, 0);
    ready_mode = 1;
    tick();
    tick();
    check("drop_released", bus.wr_en, 0);
    check("overflow_sticky", bus.overflow, 1);
    ready_mode = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_din", bus.din, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_rx_ready", bus.rx_ready, 1);
    check("rst_overflow", bus.overflow, 0);
    check("rst_wrapped", bus.wrapped, 0);
    tick();
    rst_n = 1'b1;
    byte_q.delete();
    exp_q.delete();
    exp_addr = 0;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    bus.wr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.wr_ready = ($urandom_range(0, 3) != 0);
        1:       bus.wr_ready = 1'b1;
        default: bus.wr_ready = 1'b0;
      endcase
    end
  end

  initial begin
    bit wrap_due;
    wrap_due = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wrap_due = 1'b0;
      end else begin
        check("wrapped", bus.wrapped, wrap_due);
        if (bus.wrapped) seen_wraps++;
        wrap_due = 1'b0;
        if (bus.wr_en) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_write: wr_en=1 addr=%0d din=0x%0h, expected no write", bus.wr_addr, bus.din);
          end else begin
            check("wr_addr", bus.wr_addr, exp_q[0].addr);
            check("din", bus.din, exp_q[0].data);
            if (bus.wr_ready) begin
              wrap_due = (exp_q[0].addr == DEPTH - 1);
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int r;
    bus.controll   = OP_VOID;
    bus.rx_data    = '0;
    bus.rx_valid   = 1'b0;
    bus.alu_result = '0;
    bus.alu_valid  = 1'b0;
    tick();
    do_reset();

    ready_mode = 1;
    tick();
    send_byte(8'h34);
    check("t1_wr_en_early", bus.wr_en, 0);
    send_byte(8'h12);
    check("t1_wr_en", bus.wr_en, 1);
    check("t1_din", bus.din, 16'h1234);
    check("t1_addr", bus.wr_addr, 0);
    tick();
    check("t1_wr_en_one_cycle", bus.wr_en, 0);
    check("t1_addr_next", bus.wr_addr, 1);

    alu_write(OP_SHOWMUL, 24'hABCDEF);
    alu_write(OP_SHOWADD, 24'h00BEEF);
    send_byte(8'hAB);
    void_op();

    for (int i = 0; i < DEPTH; i++) alu_write(OP_SHOWSUB, RES_W'($urandom));
    tick();
    tick();
    check("t5_addr_back", bus.wr_addr, 0);

    drop_test(3);
    void_op();

    send_byte(8'h77);
    do_reset();
    tick();
    check("t6_no_write", bus.wr_en, 0);
    send_byte(8'h01);
    send_byte(8'h02);

    ready_mode = 0;
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        send_byte(BYTE_W'($urandom));
      end else if (r == 8) begin
        void_op();
      end else begin
        if (byte_q.size() != 0) flush(4'($urandom_range(2, 15)), 1'($urandom));
        if (r == 5)      alu_write(4'(4 + 2 * $urandom_range(0, 3)), RES_W'($urandom));
        else if (r == 9) begin
          if ($urandom_range(0, 3) == 0) drop_test($urandom_range(1, 4));
          else idle_op();
        end
        else idle_op();
      end
    end

    if (byte_q.size() != 0) flush(quiet_op(), 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain_pending_writes", exp_q.size(), 0);
    tick();
    tick();
    check("wrap_count", seen_wraps, exp_wraps);
    check("final_overflow", bus.overflow, exp_ovf);
    check("final_wr_addr", bus.wr_addr, exp_addr);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
